// File: rtl/hazard_scoreboard.sv
// Per-register RAW scoreboard for a 4-stage pipeline: counts down cycles until each
// in-flight write is visible to decode, and stalls decode while a source is pending.
module hazard_scoreboard #(
  parameter int LAT = 3,
  parameter int CW  = 3,
  parameter int SCW = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           issueValid,
  input  logic [2:0]     rd1Sel,
  input  logic           rd1Used,
  input  logic [2:0]     rd2Sel,
  input  logic           rd2Used,
  input  logic           wrEn,
  input  logic [2:0]     wrSel,
  input  logic           doBranch,
  input  logic           memStall,
  output logic           hazStall,
  output logic [7:0]     busy,
  output logic           pipeEmpty,
  output logic [SCW-1:0] stallCnt
);

  logic [CW-1:0] count [8];
  logic          conflict;
  logic          alloc;

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      busy[i] = (count[i] != '0);
    end
  end

  assign pipeEmpty = (busy == 8'h00);
  assign conflict  = (rd1Used & busy[rd1Sel]) | (rd2Used & busy[rd2Sel]);
  assign hazStall  = issueValid & conflict & ~doBranch;
  assign alloc     = issueValid & wrEn & ~hazStall & ~doBranch & ~memStall;

  // A frozen pipe holds every countdown; otherwise the youngest writer reloads LAT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) begin
        count[i] <= '0;
      end
      stallCnt <= '0;
    end else if (!memStall) begin
      for (int i = 0; i < 8; i++) begin
        if (alloc && (wrSel == i[2:0])) begin
          count[i] <= CW'(LAT);
        end else if (count[i] != '0) begin
          count[i] <= count[i] - CW'(1);
        end
      end
      if (hazStall && (stallCnt != '1)) begin
        stallCnt <= stallCnt + SCW'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench: the driver pushes expected outputs from a ready-time model,
// and a separate monitor pops and compares them each cycle.
module tb_hazard_scoreboard;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        issueValid = 1'b0;
  logic [2:0]  rd1Sel = '0;
  logic        rd1Used = 1'b0;
  logic [2:0]  rd2Sel = '0;
  logic        rd2Used = 1'b0;
  logic        wrEn = 1'b0;
  logic [2:0]  wrSel = '0;
  logic        doBranch = 1'b0;
  logic        memStall = 1'b0;

  logic        hazStall, pipeEmpty;
  logic [7:0]  busy;
  logic [15:0] stallCnt;
  logic        hazStallS, pipeEmptyS;
  logic [7:0]  busyS;
  logic [2:0]  stallCntS;

  hazard_scoreboard #(.LAT(LAT), .CW(3), .SCW(16)) dut (
    .clk(clk), .rst(rst), .issueValid(issueValid),
    .rd1Sel(rd1Sel), .rd1Used(rd1Used), .rd2Sel(rd2Sel), .rd2Used(rd2Used),
    .wrEn(wrEn), .wrSel(wrSel), .doBranch(doBranch), .memStall(memStall),
    .hazStall(hazStall), .busy(busy), .pipeEmpty(pipeEmpty), .stallCnt(stallCnt)
  );

  // Narrow stall counter so saturation is reached within a short run.
  hazard_scoreboard #(.LAT(LAT), .CW(3), .SCW(3)) dutSat (
    .clk(clk), .rst(rst), .issueValid(issueValid),
    .rd1Sel(rd1Sel), .rd1Used(rd1Used), .rd2Sel(rd2Sel), .rd2Used(rd2Used),
    .wrEn(wrEn), .wrSel(wrSel), .doBranch(doBranch), .memStall(memStall),
    .hazStall(hazStallS), .busy(busyS), .pipeEmpty(pipeEmptyS), .stallCnt(stallCntS)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        hz;
    logic [7:0]  bsy;
    logic        pe;
    logic [15:0] sc;
    logic [2:0]  scSat;
  } exp_t;

  exp_t expQ[$];
  int checks = 0;
  int errors = 0;

  // Model: a register is pending while the number of completed edges is below its ready time.
  int readyAt[8];
  int edges = 0;
  int stallTotal = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic bit pend(input int r);
    return readyAt[r] > edges;
  endfunction

  task automatic cyc(input bit iv, input int r1, input bit u1, input int r2, input bit u2,
                     input bit we, input int ws, input bit br, input bit ms);
    exp_t e;
    bit conf, hz;
    @(negedge clk);
    issueValid = iv; rd1Sel = 3'(r1); rd1Used = u1; rd2Sel = 3'(r2); rd2Used = u2;
    wrEn = we; wrSel = 3'(ws); doBranch = br; memStall = ms;
    conf = (u1 && pend(r1)) || (u2 && pend(r2));
    hz = iv && conf && !br;
    e.hz = hz;
    e.bsy = '0;
    for (int i = 0; i < 8; i++) e.bsy[i] = pend(i);
    e.pe = (e.bsy == 8'h00);
    e.sc = (stallTotal > 65535) ? 16'hFFFF : 16'(stallTotal);
    e.scSat = (stallTotal > 7) ? 3'd7 : 3'(stallTotal);
    expQ.push_back(e);
    if (ms) begin
      for (int i = 0; i < 8; i++) if (pend(i)) readyAt[i]++;
      edges++;
    end else begin
      edges++;
      if (iv && we && !hz && !br) readyAt[ws] = edges + LAT;
      if (hz) stallTotal++;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b0;
    issueValid = 1'b1; rd1Sel = 3'd3; rd1Used = 1'b1; rd2Used = 1'b0;
    wrEn = 1'b0; doBranch = 1'b0; memStall = 1'b0;
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_pipeEmpty", int'(pipeEmpty), 1);
    check("rst_stallCnt", int'(stallCnt), 0);
    check("rst_hazStall", int'(hazStall), 0);
    check("rst_satCnt", int'(stallCntS), 0);
    for (int i = 0; i < 8; i++) readyAt[i] = 0;
    stallTotal = 0;
    @(posedge clk);
    #1;
    issueValid = 1'b0; rd1Used = 1'b0;
    rst = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      while (expQ.size() > 0) begin
        e = expQ.pop_front();
        check("hazStall", int'(hazStall), int'(e.hz));
        check("busy", int'(busy), int'(e.bsy));
        check("pipeEmpty", int'(pipeEmpty), int'(e.pe));
        check("stallCnt", int'(stallCnt), int'(e.sc));
        check("satStallCnt", int'(stallCntS), int'(e.scSat));
        check("satHazStall", int'(hazStallS), int'(e.hz));
      end
    end
  end

  initial begin : driver
    for (int i = 0; i < 8; i++) readyAt[i] = 0;
    repeat (2) @(negedge clk);
    doReset();

    // back-to-back RAW on r2
    cyc(1, 0, 0, 0, 0, 1, 2, 0, 0);
    repeat (3) cyc(1, 2, 1, 0, 0, 0, 0, 0, 0);
    idle(3);

    // unused operand: pending r5 read with rd2Used=0, new writer r6
    cyc(1, 0, 0, 0, 0, 1, 5, 0, 0);
    cyc(1, 0, 0, 5, 0, 1, 6, 0, 0);
    idle(4);

    // memStall freeze with dependent of r4 in decode
    cyc(1, 0, 0, 0, 0, 1, 4, 0, 0);
    idle(1);
    repeat (3) cyc(1, 4, 1, 0, 0, 0, 0, 0, 1);
    repeat (3) cyc(1, 4, 1, 0, 0, 0, 0, 0, 0);
    idle(2);

    // branch squash, alone and with a conflicting read
    cyc(1, 0, 0, 0, 0, 1, 7, 1, 0);
    cyc(1, 0, 0, 0, 0, 1, 3, 0, 0);
    cyc(1, 3, 1, 0, 0, 1, 7, 1, 0);
    idle(4);

    // WAW: reallocate r1 while its count is 1
    cyc(1, 0, 0, 0, 0, 1, 1, 0, 0);
    idle(2);
    cyc(1, 0, 0, 0, 0, 1, 1, 0, 0);
    idle(4);

    // same-register read/write chain accumulates stalls
    repeat (12) cyc(1, 1, 1, 0, 0, 1, 1, 0, 0);

    // asynchronous reset with r3 two cycles from ready
    cyc(1, 0, 0, 0, 0, 1, 3, 0, 0);
    idle(1);
    doReset();

    for (int k = 0; k < 3000; k++) begin
      cyc(($urandom_range(0, 9) < 8), int'($urandom_range(0, 7)), 1'($urandom),
          int'($urandom_range(0, 7)), 1'($urandom), ($urandom_range(0, 3) != 0),
          int'($urandom_range(0, 7)), ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 7) == 0));
    end
    idle(3);
    repeat (3) @(negedge clk);
    #4;
    check("queueDrained", expQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
